slot_bus_ctrl: RTL and testbench
================================

// Module: slot_bus_ctrl
// PURPOSE
//  Parametrised Apple IIgs peripheral-slot bus controller replacing the hard-wired slot-7 decode.
//  Generates per-slot DEVSEL/IOSEL and tracks C800-CFFF expansion-ROM ownership (IOSTROBE latch).
//  Registers slot read data on the phi0 strobe and inserts wait states for slow cards.
//  Sits between the core address bus and slot devices (hdd, future disk/serial); output feeds the din mux.
// PARAMETERS
//  NSLOTS      7      slots 1..NSLOTS decoded (1..7); higher slot numbers never selected
//  SLOW_MASK   8'h00  bit n=1: slot n is slow and accesses stall the CPU
//  WAIT_PHI0   2      extra phi0 strobes held in wait per slow access (1..15)
// PORTS
//  clk_sys        in   1          system clock
//  reset          in   1          synchronous, active-high
//  phi0           in   1          one-clk_sys-wide CPU cycle strobe (fast_clk)
//  bank           in   8          CPU bank
//  addr           in   16         CPU address
//  we             in   1          1=write, 0=read
//  sltromsel      in   8          bit n=1: slot n external card, 0: internal ROM
//  cxrom          in   1          1: internal ROM owns Cn00-CFFF, slot ROM space disabled
//  slot_dout      in   8*NSLOTS   read data, slot n at [8n-1:8n-8]
//  device_select  out  NSLOTS     bit n-1: C0(8+n)0-C0(8+n)F access to slot n
//  io_select      out  NSLOTS     bit n-1: Cn00-CnFF access to slot n
//  io_strobe      out  1          C800-CFFE access owned by a slot
//  exp_owner      out  3          current C800 owner slot, 0=none
//  slot_claim     out  1          any select/strobe active (top mux picks slot_rdata)
//  slot_rdata     out  8          registered read data of selected slot
//  cpu_wait       out  1          stall request to core
//  irq_mask       in   NSLOTS     (SLOT_IRQ_EN) 1=slot IRQ enabled
//  slot_irq       in   NSLOTS     (SLOT_IRQ_EN) active-high slot interrupt requests
//  irq            out  1          (SLOT_IRQ_EN) aggregated interrupt
//  irq_src        out  3          (SLOT_IRQ_EN) lowest-numbered pending slot, 0=none
// BEHAVIOUR
//  - io_space = bank in {00,01,E0,E1}. All decode combinational, same cycle as addr.
//  - device_select[n-1]=io_space & addr[15:4]==C08+n & sltromsel[n].
//  - io_select[n-1]=io_space & addr[15:8]==C0+n & sltromsel[n] & ~cxrom.
//  - io_strobe=io_space & C800<=addr<=CFFE & exp_owner!=0 & sltromsel[exp_owner] & ~cxrom.
//  - exp_owner: updates only on phi0 when FSM IDLE. io_select[n-1] -> n. io_space access to CFFF
//    (read or write, regardless of cxrom) -> 0. Reset -> 0.
//  - slot_rdata: on phi0, read (we=0) with a select active -> captures the selected slot's byte;
//    io_strobe reads use exp_owner's byte. Otherwise holds. Reset -> 8'h00. Latency 1 clk after phi0.
//  - Wait FSM IDLE/STALL: IDLE + phi0 + access to slot with SLOW_MASK[n] -> STALL, cnt=WAIT_PHI0.
//    STALL: cpu_wait=1; each phi0 decrements cnt; cnt==1 on phi0 -> IDLE. Selects stay driven.
//    Reset mid-stall -> IDLE, cpu_wait=0 next clock.
//  - Reset values: cpu_wait 0, exp_owner 0, slot_rdata 00, irq 0, irq_src 0.
// CONFIGURATION
//  SLOT_IRQ_EN defined: slot_irq double-flop synchronised; irq=|(sync&irq_mask), registered;
//    irq_src=lowest n pending; 2-clk latency input->irq.
//  Not defined: IRQ input ports unused, irq=0, irq_src=0 constant.
// STRUCTURE
//  iigs_slot_pkg: IO bank constants, C090/Cn00/C800/CFFF address constants, slot index type (3b),
//    FSM state enum.
//  Sub-module slot_wait_fsm: IDLE/STALL + 4-bit counter; rest inline.
// TESTING
//  - bank 00, addr C0F2 read, sltromsel=80 -> device_select[6]=1; sltromsel=00 -> all 0.
//  - read C700 at phi0, sltromsel=80, cxrom=0 -> exp_owner=7; then read C900 -> io_strobe=1,
//    slot_rdata=slot7 byte 1 clk after phi0.
//  - owner=7, access CFFF -> exp_owner=0; C900 -> io_strobe=0. Repeat with cxrom=1: CFFF still clears.
//  - SLOW_MASK=80, WAIT_PHI0=2: read C0F0 -> cpu_wait=1 for exactly 2 phi0 periods; reset mid-stall
//    -> cpu_wait=0 next clock.
//  - bank 02 addr C700 -> no selects, exp_owner unchanged.
//  - SLOT_IRQ_EN: slot_irq=0x24, mask=0x7F -> irq=1, irq_src=3 within 2 clk; mask=0 -> irq=0.

Source files
------------

// File: rtl/iigs_slot_pkg.sv
// Shared definitions for the Apple IIgs peripheral-slot bus controller:
// I/O bank numbers, slot address map anchors, slot index type and the
// wait-state FSM encoding.
package iigs_slot_pkg;

  // Banks in which the slot I/O map is visible
  localparam logic [7:0] IO_BANK_00 = 8'h00;
  localparam logic [7:0] IO_BANK_01 = 8'h01;
  localparam logic [7:0] IO_BANK_E0 = 8'hE0;
  localparam logic [7:0] IO_BANK_E1 = 8'hE1;

  // Slot 1 DEVSEL window starts at C090; slot n sits 16 bytes further on
  localparam logic [15:0] ADDR_DEVSEL_S1 = 16'hC090;
  // Cn00 page base with n = 0; slot n's IOSEL page is n pages above
  localparam logic [15:0] ADDR_IOSEL_S0  = 16'hC000;
  // Shared expansion ROM window and its release location
  localparam logic [15:0] ADDR_EXP_LO    = 16'hC800;
  localparam logic [15:0] ADDR_EXP_HI    = 16'hCFFE;
  localparam logic [15:0] ADDR_EXP_CLR   = 16'hCFFF;

  // Slot number 1..7, 0 means "no slot"
  typedef logic [2:0] slot_idx_t;

  typedef enum logic {
    WAIT_IDLE  = 1'b0,
    WAIT_STALL = 1'b1
  } wait_state_t;

  function automatic logic is_io_bank(input logic [7:0] bank);
    return (bank == IO_BANK_00) || (bank == IO_BANK_01) ||
           (bank == IO_BANK_E0) || (bank == IO_BANK_E1);
  endfunction

endpackage

// File: rtl/slot_wait_fsm.sv
// Wait-state generator for slow slot cards. A slow access seen on a phi0
// strobe holds the CPU for WAIT_PHI0 further phi0 strobes.
module slot_wait_fsm #(
  parameter int WAIT_PHI0 = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_phi0,
  input  logic i_slow_hit,
  output logic o_wait,
  output logic o_idle
);
  import iigs_slot_pkg::*;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_PHI0);

  wait_state_t r_state;
  wait_state_t w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;

  // State and remaining-strobe counter registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= WAIT_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: load on a slow access, count phi0 strobes down while stalled
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      WAIT_IDLE: begin
        if (i_phi0 && i_slow_hit) begin
          w_state_nxt = WAIT_STALL;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      WAIT_STALL: begin
        if (i_phi0) begin
          if (r_cnt == 4'd1) begin
            w_state_nxt = WAIT_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt - 4'd1;
          end
        end
      end
      default: begin
        w_state_nxt = WAIT_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_wait = (r_state == WAIT_STALL);
  assign o_idle = (r_state == WAIT_IDLE);

endmodule

// File: rtl/slot_bus_ctrl.sv
// Apple IIgs peripheral-slot bus controller: per-slot DEVSEL/IOSEL decode,
// C800-CFFF expansion ROM ownership, registered slot read data and wait
// states for slow cards.
// Optional build macro SLOT_IRQ_EN adds synchronised slot interrupt
// aggregation; without it irq/irq_src are tied low.
module slot_bus_ctrl #(
  parameter int         NSLOTS    = 7,
  parameter logic [7:0] SLOW_MASK = 8'h00,
  parameter int         WAIT_PHI0 = 2
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  phi0,
  input  logic [7:0]            bank,
  input  logic [15:0]           addr,
  input  logic                  we,
  input  logic [7:0]            sltromsel,
  input  logic                  cxrom,
  input  logic [8*NSLOTS-1:0]   slot_dout,
  output logic [NSLOTS-1:0]     device_select,
  output logic [NSLOTS-1:0]     io_select,
  output logic                  io_strobe,
  output logic [2:0]            exp_owner,
  output logic                  slot_claim,
  output logic [7:0]            slot_rdata,
  output logic                  cpu_wait,
  input  logic [NSLOTS-1:0]     irq_mask,
  input  logic [NSLOTS-1:0]     slot_irq,
  output logic                  irq,
  output logic [2:0]            irq_src
);
  import iigs_slot_pkg::*;

  localparam logic [7:0] SLOW_BITS = SLOW_MASK;

  logic      w_io_space;
  logic      w_exp_range;
  slot_idx_t w_iosel_slot;
  slot_idx_t r_exp_owner;
  logic [7:0] w_rd_byte;
  logic      w_rd_hit;
  logic      w_slow_hit;
  logic      w_fsm_idle;
  logic [7:0] r_rdata;

  assign w_io_space  = is_io_bank(bank);
  assign w_exp_range = (addr >= ADDR_EXP_LO) && (addr <= ADDR_EXP_HI);

  // Per-slot DEVSEL (C0n0-C0nF above C080) and IOSEL (Cn00-CnFF) decode
  always_comb begin
    device_select = '0;
    io_select     = '0;
    w_iosel_slot  = '0;
    for (int n = 1; n <= NSLOTS; n++) begin
      if (w_io_space && sltromsel[n] &&
          (addr[15:4] == ADDR_DEVSEL_S1[15:4] + 12'(n - 1)))
        device_select[n-1] = 1'b1;
      if (w_io_space && sltromsel[n] && !cxrom &&
          (addr[15:8] == ADDR_IOSEL_S0[15:8] + 8'(n))) begin
        io_select[n-1] = 1'b1;
        w_iosel_slot   = 3'(n);
      end
    end
  end

  // Expansion ROM window belongs to the owning slot only while it is external
  assign io_strobe = w_io_space && w_exp_range && (r_exp_owner != 3'd0) &&
                     sltromsel[r_exp_owner] && !cxrom;

  assign slot_claim = (|device_select) || (|io_select) || io_strobe;

  // Pick the byte and the slow flag of whichever slot the access targets
  always_comb begin
    w_rd_byte  = '0;
    w_rd_hit   = 1'b0;
    w_slow_hit = 1'b0;
    for (int n = 1; n <= NSLOTS; n++) begin
      if (device_select[n-1] || io_select[n-1]) begin
        w_rd_byte  = slot_dout[8*n-8 +: 8];
        w_rd_hit   = 1'b1;
        w_slow_hit = SLOW_BITS[n];
      end
    end
    if (io_strobe) begin
      for (int n = 1; n <= NSLOTS; n++) begin
        if (r_exp_owner == 3'(n)) begin
          w_rd_byte  = slot_dout[8*n-8 +: 8];
          w_rd_hit   = 1'b1;
          w_slow_hit = SLOW_BITS[n];
        end
      end
    end
  end

  slot_wait_fsm #(
    .WAIT_PHI0 (WAIT_PHI0)
  ) u_wait (
    .i_clk      (clk_sys),
    .i_reset    (reset),
    .i_phi0     (phi0),
    .i_slow_hit (w_slow_hit),
    .o_wait     (cpu_wait),
    .o_idle     (w_fsm_idle)
  );

  // C800 owner: claimed by a Cn00 access, released by CFFF; frozen during a stall
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_exp_owner <= '0;
    end else if (phi0 && w_fsm_idle) begin
      if (|io_select)
        r_exp_owner <= w_iosel_slot;
      else if (w_io_space && (addr == ADDR_EXP_CLR))
        r_exp_owner <= '0;
    end
  end

  // Read data captured on the phi0 strobe of a claimed read, held otherwise
  always_ff @(posedge clk_sys) begin
    if (reset)
      r_rdata <= 8'h00;
    else if (phi0 && !we && w_rd_hit)
      r_rdata <= w_rd_byte;
  end

  assign exp_owner  = r_exp_owner;
  assign slot_rdata = r_rdata;

`ifdef SLOT_IRQ_EN
  logic [NSLOTS-1:0] r_irq_sync;
  logic [NSLOTS-1:0] w_irq_pend;
  logic [2:0]        w_irq_low;
  logic              r_irq;
  logic [2:0]        r_irq_src;

  assign w_irq_pend = r_irq_sync & irq_mask;

  // Lowest-numbered enabled pending slot wins
  always_comb begin
    w_irq_low = '0;
    for (int n = NSLOTS; n >= 1; n--) begin
      if (w_irq_pend[n-1])
        w_irq_low = 3'(n);
    end
  end

  // First flop retimes the asynchronous requests, output register is the second
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_irq_sync <= '0;
      r_irq      <= 1'b0;
      r_irq_src  <= '0;
    end else begin
      r_irq_sync <= slot_irq;
      r_irq      <= |w_irq_pend;
      r_irq_src  <= w_irq_low;
    end
  end

  assign irq     = r_irq;
  assign irq_src = r_irq_src;
`else
  logic w_unused_irq;
  assign w_unused_irq = ^{irq_mask, slot_irq};
  assign irq          = 1'b0;
  assign irq_src      = 3'd0;
`endif

endmodule

// File: tb/tb_slot_bus_ctrl.sv
// Self-checking bench for slot_bus_ctrl with slot 7 configured slow
// (SLOW_MASK=80, WAIT_PHI0=2). Define SLOT_IRQ_EN to exercise the IRQ path.
module tb_slot_bus_ctrl;

  localparam int         NS   = 7;
  localparam logic [7:0] SLOW = 8'h80;
  localparam int         WP   = 2;

  logic            clk_sys = 1'b0;
  logic            reset;
  logic            phi0;
  logic [7:0]      bank;
  logic [15:0]     addr;
  logic            we;
  logic [7:0]      sltromsel;
  logic            cxrom;
  logic [8*NS-1:0] slot_dout;
  logic [NS-1:0]   device_select;
  logic [NS-1:0]   io_select;
  logic            io_strobe;
  logic [2:0]      exp_owner;
  logic            slot_claim;
  logic [7:0]      slot_rdata;
  logic            cpu_wait;
  logic [NS-1:0]   irq_mask;
  logic [NS-1:0]   slot_irq;
  logic            irq;
  logic [2:0]      irq_src;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  int         m_owner;
  logic [7:0] m_rdata;
  int         m_stall;

  slot_bus_ctrl #(
    .NSLOTS    (NS),
    .SLOW_MASK (SLOW),
    .WAIT_PHI0 (WP)
  ) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .phi0          (phi0),
    .bank          (bank),
    .addr          (addr),
    .we            (we),
    .sltromsel     (sltromsel),
    .cxrom         (cxrom),
    .slot_dout     (slot_dout),
    .device_select (device_select),
    .io_select     (io_select),
    .io_strobe     (io_strobe),
    .exp_owner     (exp_owner),
    .slot_claim    (slot_claim),
    .slot_rdata    (slot_rdata),
    .cpu_wait      (cpu_wait),
    .irq_mask      (irq_mask),
    .slot_irq      (slot_irq),
    .irq           (irq),
    .irq_src       (irq_src)
  );

  always #5 clk_sys = ~clk_sys;

  // ---------------- reference model ----------------
  function automatic bit m_is_io(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'h01) || (b == 8'hE0) || (b == 8'hE1);
  endfunction

  function automatic int m_dev_slot();
    int a = int'(addr);
    int s;
    if (!m_is_io(bank) || a < 32'hC090 || a > 32'hC08F + 16 * NS) return 0;
    s = (a - 32'hC080) / 16;
    return sltromsel[s] ? s : 0;
  endfunction

  function automatic int m_io_slot();
    int a = int'(addr);
    int s;
    if (!m_is_io(bank) || cxrom || a < 32'hC100 || a > 32'hC0FF + 256 * NS) return 0;
    s = (a - 32'hC000) / 256;
    return sltromsel[s] ? s : 0;
  endfunction

  function automatic bit m_strobe();
    int a = int'(addr);
    return m_is_io(bank) && !cxrom && a >= 32'hC800 && a <= 32'hCFFE &&
           m_owner != 0 && sltromsel[m_owner];
  endfunction

  task automatic model_update();
    int ds, is, tgt;
    bit st;
    if (reset) begin
      m_owner = 0; m_rdata = 8'h00; m_stall = 0;
    end else if (phi0) begin
      ds  = m_dev_slot();
      is  = m_io_slot();
      st  = m_strobe();
      tgt = (ds != 0) ? ds : (is != 0) ? is : st ? m_owner : 0;
      if (!we && tgt != 0) m_rdata = slot_dout[8*tgt-8 +: 8];
      if (m_stall == 0) begin
        if (tgt != 0 && SLOW[tgt]) m_stall = WP;
        if (is != 0) m_owner = is;
        else if (m_is_io(bank) && addr == 16'hCFFF) m_owner = 0;
      end else begin
        m_stall = m_stall - 1;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_bus(input logic [7:0] b, input logic [15:0] a, input logic w,
                         input logic [7:0] sel, input logic cx);
    bank = b; addr = a; we = w; sltromsel = sel; cxrom = cx;
    #1;
  endtask

  task automatic clk_cycle(input logic ph);
    phi0 = ph;
    @(posedge clk_sys);
    model_update();
    @(negedge clk_sys);
    phi0 = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk_sys);
    model_update();
    @(negedge clk_sys);
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    set_bus(8'h00, 16'hC700, 1'b0, 8'h80, 1'b0);
    slot_dout[55:48] = 8'hA5;
    clk_cycle(1'b1);
    do_reset();
    n_total++; if (cpu_wait !== 1'b0) $display("FAIL reset_wait: got %b want 0", cpu_wait); else n_pass++;
    n_total++; if (exp_owner !== 3'd0) $display("FAIL reset_owner: got %0d want 0", exp_owner); else n_pass++;
    n_total++; if (slot_rdata !== 8'h00) $display("FAIL reset_rdata: got %h want 00", slot_rdata); else n_pass++;
    n_total++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else n_pass++;
    n_total++; if (irq_src !== 3'd0) $display("FAIL reset_irq_src: got %0d want 0", irq_src); else n_pass++;
  endtask

  task automatic test_devsel();
    set_bus(8'h00, 16'hC0F2, 1'b0, 8'h80, 1'b0);
    n_total++; if (device_select !== 7'h40) $display("FAIL devsel_s7: got %h want 40", device_select); else n_pass++;
    n_total++; if (slot_claim !== 1'b1) $display("FAIL devsel_claim: got %b want 1", slot_claim); else n_pass++;
    set_bus(8'h00, 16'hC0F2, 1'b0, 8'h00, 1'b0);
    n_total++; if (device_select !== 7'h00) $display("FAIL devsel_internal: got %h want 00", device_select); else n_pass++;
    n_total++; if (slot_claim !== 1'b0) $display("FAIL devsel_noclaim: got %b want 0", slot_claim); else n_pass++;
    set_bus(8'hE1, 16'hC09A, 1'b1, 8'h02, 1'b1);
    n_total++; if (device_select !== 7'h01) $display("FAIL devsel_s1_cxrom: got %h want 01", device_select); else n_pass++;
    set_bus(8'h01, 16'hC3FF, 1'b0, 8'h08, 1'b0);
    n_total++; if (io_select !== 7'h04) $display("FAIL iosel_s3: got %h want 04", io_select); else n_pass++;
  endtask

  task automatic test_exp_rom();
    do_reset();
    set_bus(8'h00, 16'hC700, 1'b0, 8'h80, 1'b0);
    n_total++; if (io_select !== 7'h40) $display("FAIL iosel_s7: got %h want 40", io_select); else n_pass++;
    slot_dout[55:48] = 8'hA7;
    clk_cycle(1'b1);
    n_total++; if (exp_owner !== 3'd7) $display("FAIL owner_claim: got %0d want 7", exp_owner); else n_pass++;
    n_total++; if (slot_rdata !== 8'hA7) $display("FAIL rdata_iosel: got %h want a7", slot_rdata); else n_pass++;
    set_bus(8'h00, 16'hC900, 1'b0, 8'h80, 1'b0);
    slot_dout[55:48] = 8'h5C;
    #1;
    n_total++; if (io_strobe !== 1'b1) $display("FAIL strobe_on: got %b want 1", io_strobe); else n_pass++;
    clk_cycle(1'b1);
    n_total++; if (slot_rdata !== 8'h5C) $display("FAIL rdata_strobe: got %h want 5c", slot_rdata); else n_pass++;
    set_bus(8'h00, 16'hC900, 1'b1, 8'h80, 1'b0);
    slot_dout[55:48] = 8'h33;
    clk_cycle(1'b1);
    n_total++; if (slot_rdata !== 8'h5C) $display("FAIL rdata_write_hold: got %h want 5c", slot_rdata); else n_pass++;
  endtask

  task automatic test_cfff_clear();
    do_reset();
    set_bus(8'h00, 16'hC700, 1'b0, 8'h80, 1'b0);
    clk_cycle(1'b1);
    set_bus(8'h02, 16'h0000, 1'b0, 8'h80, 1'b0);
    clk_cycle(1'b1); clk_cycle(1'b1);
    set_bus(8'h00, 16'hCFFF, 1'b1, 8'h80, 1'b0);
    clk_cycle(1'b1);
    n_total++; if (exp_owner !== 3'd0) $display("FAIL cfff_clear: got %0d want 0", exp_owner); else n_pass++;
    set_bus(8'h00, 16'hC900, 1'b0, 8'h80, 1'b0);
    n_total++; if (io_strobe !== 1'b0) $display("FAIL strobe_after_clear: got %b want 0", io_strobe); else n_pass++;
    set_bus(8'h00, 16'hC700, 1'b0, 8'h80, 1'b0);
    clk_cycle(1'b1);
    set_bus(8'h02, 16'h0000, 1'b0, 8'h80, 1'b0);
    clk_cycle(1'b1); clk_cycle(1'b1);
    set_bus(8'h00, 16'hC900, 1'b0, 8'h80, 1'b1);
    n_total++; if (io_strobe !== 1'b0) $display("FAIL strobe_cxrom: got %b want 0", io_strobe); else n_pass++;
    set_bus(8'h00, 16'hCFFF, 1'b0, 8'h80, 1'b1);
    clk_cycle(1'b1);
    n_total++; if (exp_owner !== 3'd0) $display("FAIL cfff_clear_cxrom: got %0d want 0", exp_owner); else n_pass++;
  endtask

  task automatic test_slow_wait();
    int  k = 0;
    bit  held = 1'b1;
    do_reset();
    set_bus(8'h00, 16'hC0F0, 1'b0, 8'h80, 1'b0);
    clk_cycle(1'b1);
    n_total++; if (cpu_wait !== 1'b1) $display("FAIL wait_enter: got %b want 1", cpu_wait); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      clk_cycle(1'b0);
      if (cpu_wait !== 1'b1 || device_select !== 7'h40) held = 1'b0;
      clk_cycle(1'b1);
      k++;
      if (cpu_wait === 1'b0) break;
    end
    n_total++; if (k != WP) $display("FAIL wait_phi0_count: got %0d want %0d", k, WP); else n_pass++;
    n_total++; if (!held) $display("FAIL wait_held: wait or select dropped between strobes"); else n_pass++;
    set_bus(8'h00, 16'hC0E0, 1'b0, 8'h40, 1'b0);
    clk_cycle(1'b1);
    n_total++; if (cpu_wait !== 1'b0) $display("FAIL wait_fast_slot: got %b want 0", cpu_wait); else n_pass++;
    set_bus(8'h00, 16'hC0F0, 1'b0, 8'h80, 1'b0);
    clk_cycle(1'b1);
    n_total++; if (cpu_wait !== 1'b1) $display("FAIL wait_reenter: got %b want 1", cpu_wait); else n_pass++;
    do_reset();
    n_total++; if (cpu_wait !== 1'b0) $display("FAIL wait_reset_mid: got %b want 0", cpu_wait); else n_pass++;
  endtask

  task automatic test_non_io_bank();
    do_reset();
    set_bus(8'h00, 16'hC700, 1'b0, 8'h80, 1'b0);
    clk_cycle(1'b1);
    set_bus(8'h02, 16'hC700, 1'b0, 8'h80, 1'b0);
    n_total++; if (io_select !== 7'h00) $display("FAIL bank02_iosel: got %h want 00", io_select); else n_pass++;
    n_total++; if (slot_claim !== 1'b0) $display("FAIL bank02_claim: got %b want 0", slot_claim); else n_pass++;
    clk_cycle(1'b1);
    set_bus(8'h02, 16'hCFFF, 1'b0, 8'h80, 1'b0);
    clk_cycle(1'b1); clk_cycle(1'b1);
    n_total++; if (exp_owner !== 3'd7) $display("FAIL bank02_owner: got %0d want 7", exp_owner); else n_pass++;
    set_bus(8'h02, 16'hC900, 1'b0, 8'h80, 1'b0);
    n_total++; if (io_strobe !== 1'b0) $display("FAIL bank02_strobe: got %b want 0", io_strobe); else n_pass++;
    set_bus(8'hE0, 16'hC900, 1'b0, 8'h80, 1'b0);
    n_total++; if (io_strobe !== 1'b1) $display("FAIL bankE0_strobe: got %b want 1", io_strobe); else n_pass++;
  endtask

  task automatic test_irq();
    int exp_src;
`ifdef SLOT_IRQ_EN
    slot_irq = 7'h24; irq_mask = 7'h7F;
    @(posedge clk_sys); @(posedge clk_sys); @(negedge clk_sys);
    n_total++; if (irq !== 1'b1) $display("FAIL irq_on: got %b want 1", irq); else n_pass++;
    n_total++; if (irq_src !== 3'd3) $display("FAIL irq_src: got %0d want 3", irq_src); else n_pass++;
    irq_mask = 7'h00;
    @(posedge clk_sys); @(posedge clk_sys); @(negedge clk_sys);
    n_total++; if (irq !== 1'b0) $display("FAIL irq_masked: got %b want 0", irq); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      slot_irq = 7'($urandom); irq_mask = 7'($urandom);
      repeat (3) @(posedge clk_sys);
      @(negedge clk_sys);
      exp_src = 0;
      for (int n = NS; n >= 1; n--) if (slot_irq[n-1] && irq_mask[n-1]) exp_src = n;
      n_total++; if (irq !== (exp_src != 0)) $display("FAIL irq_rand: got %b want %b", irq, exp_src != 0); else n_pass++;
      n_total++; if (int'(irq_src) != exp_src) $display("FAIL irq_src_rand: got %0d want %0d", irq_src, exp_src); else n_pass++;
    end
`else
    exp_src = 0;
    for (int i = 0; i < 8; i++) begin
      slot_irq = 7'($urandom); irq_mask = 7'($urandom);
      repeat (3) @(posedge clk_sys);
      @(negedge clk_sys);
      n_total++; if (irq !== 1'b0) $display("FAIL irq_disabled: got %b want 0", irq); else n_pass++;
      n_total++; if (int'(irq_src) != exp_src) $display("FAIL irq_src_disabled: got %0d want 0", irq_src); else n_pass++;
    end
`endif
    slot_irq = '0; irq_mask = '0;
  endtask

  task automatic test_random();
    logic [7:0]    b;
    logic [15:0]   a;
    logic [NS-1:0] e_dev, e_ios;
    int            ds, is;
    bit            st;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 4))
        0: b = 8'h00;
        1: b = 8'h01;
        2: b = 8'hE0;
        3: b = 8'hE1;
        default: b = 8'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: a = 16'(32'hC080 + $urandom_range(0, 127));
        1: a = 16'(32'hC000 + 256 * $urandom_range(0, 8) + $urandom_range(0, 255));
        2: a = 16'(32'hC800 + $urandom_range(0, 16'h7FF));
        3: a = 16'hCFFF;
        4: a = 16'(32'hC700 + $urandom_range(0, 255));
        default: a = 16'($urandom);
      endcase
      slot_dout = {$urandom, $urandom};
      set_bus(b, a, 1'($urandom_range(0, 1)),
              8'($urandom) | (($urandom_range(0, 3) != 0) ? 8'h80 : 8'h00),
              ($urandom_range(0, 7) == 0));
      ds = m_dev_slot(); is = m_io_slot(); st = m_strobe();
      e_dev = '0; e_ios = '0;
      if (ds != 0) e_dev[ds-1] = 1'b1;
      if (is != 0) e_ios[is-1] = 1'b1;
      n_total++; if (device_select !== e_dev) $display("FAIL rnd_devsel: got %h want %h at %h:%h", device_select, e_dev, bank, addr); else n_pass++;
      n_total++; if (io_select !== e_ios) $display("FAIL rnd_iosel: got %h want %h at %h:%h", io_select, e_ios, bank, addr); else n_pass++;
      n_total++; if (io_strobe !== st) $display("FAIL rnd_strobe: got %b want %b at %h:%h", io_strobe, st, bank, addr); else n_pass++;
      n_total++; if (slot_claim !== (ds != 0 || is != 0 || st)) $display("FAIL rnd_claim: got %b at %h:%h", slot_claim, bank, addr); else n_pass++;
      if ($urandom_range(0, 63) == 0) do_reset();
      else clk_cycle($urandom_range(0, 2) == 0);
      n_total++; if (int'(exp_owner) != m_owner) $display("FAIL rnd_owner: got %0d want %0d", exp_owner, m_owner); else n_pass++;
      n_total++; if (slot_rdata !== m_rdata) $display("FAIL rnd_rdata: got %h want %h", slot_rdata, m_rdata); else n_pass++;
      n_total++; if (cpu_wait !== (m_stall != 0)) $display("FAIL rnd_wait: got %b want %b", cpu_wait, m_stall != 0); else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1; phi0 = 1'b0; bank = 8'h00; addr = 16'h0000; we = 1'b0;
    sltromsel = 8'h00; cxrom = 1'b0; slot_dout = '0; irq_mask = '0; slot_irq = '0;
    m_owner = 0; m_rdata = 8'h00; m_stall = 0;
    @(negedge clk_sys);
    do_reset();
    test_reset();
    test_devsel();
    test_exp_rom();
    test_cfff_clear();
    test_slow_wait();
    test_non_io_bank();
    test_irq();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
